// File: rtl/systolic_drain.sv
// systolic_drain: output stage downstream of the systolic core.
//
// On a done_in pulse (accepted only in IDLE) the four 64-bit row accumulators
// and the layer scale are captured. The four lanes are then requantized one per
// cycle (Q16.16 multiply, round half up, saturate to int32), pushed into a small
// FIFO and streamed out one 32-bit word per valid/ready transfer.
//
// Build option: define RELU_EN to clamp negative results to zero before the push.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-low reset
//   done_in           single-cycle pulse; Re1..Re4 and layer_scale valid with it
//   Re1..Re4          signed 64-bit row accumulators
//   layer_scale       unsigned Q(32-FRAC_BITS).FRAC_BITS scale
//   out_data/out_lane requantized word and its row index at the FIFO head
//   out_valid         FIFO not empty
//   out_ready         consumer accepts the head word
//   busy              high while not IDLE
//   drop_err          sticky flag: a done_in pulse was ignored
//   clr_err           synchronous clear of drop_err (a same-cycle drop wins)

module systolic_drain #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned FRAC_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        done_in,
    input  logic [63:0] Re1,
    input  logic [63:0] Re2,
    input  logic [63:0] Re3,
    input  logic [63:0] Re4,
    input  logic [31:0] layer_scale,
    output logic [31:0] out_data,
    output logic [1:0]  out_lane,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        drop_err,
    input  logic        clr_err
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    localparam logic signed [96:0] RoundBias = 97'sd1 <<< (FRAC_BITS - 1);
    localparam logic signed [96:0] SatMax    = 97'sd2147483647;
    localparam logic signed [96:0] SatMin    = -97'sd2147483648;

    typedef enum logic [0:0] {StIdle, StScale} state_e;

    state_e state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [63:0] cap_re_q [4];
    logic [31:0] cap_scale_q;

    logic [33:0]     mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            drop_err_q;

    logic push, pop, drop;
    logic signed [63:0] sel_re;
    logic signed [96:0] prod;
    logic signed [96:0] rnd;
    logic [31:0]        sat_val;
    logic [31:0]        result;
    logic [33:0]        head;

    // Push is decided by the count at the start of the cycle only, so a
    // same-cycle pop never opens a slot in a full FIFO.
    assign push      = (state_q == StScale) && (count_q != DepthCnt);
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign drop      = (state_q == StScale) && done_in;
    assign busy      = (state_q != StIdle);
    assign drop_err  = drop_err_q;

    // Requantization of the current lane.
    always_comb begin
        sel_re = $signed(cap_re_q[lane_q]);
        // Scale is zero-extended; low 97 bits of the product are exact.
        prod   = 97'(sel_re) * 97'(cap_scale_q);
        rnd    = (prod + RoundBias) >>> FRAC_BITS;
        if (rnd > SatMax) begin
            sat_val = 32'h7FFF_FFFF;
        end else if (rnd < SatMin) begin
            sat_val = 32'h8000_0000;
        end else begin
            sat_val = rnd[31:0];
        end
`ifdef RELU_EN
        result = sat_val[31] ? 32'd0 : sat_val;
`else
        result = sat_val;
`endif
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        unique case (state_q)
            StIdle: begin
                if (done_in) begin
                    state_d = StScale;
                    lane_d  = 2'd0;
                end
            end
            StScale: begin
                if (push) begin
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            lane_q      <= 2'd0;
            cap_scale_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cap_re_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            if ((state_q == StIdle) && done_in) begin
                cap_re_q[0] <= Re1;
                cap_re_q[1] <= Re2;
                cap_re_q[2] <= Re3;
                cap_re_q[3] <= Re4;
                cap_scale_q <= layer_scale;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_err_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (drop) begin
                drop_err_q <= 1'b1;
            end else if (clr_err) begin
                drop_err_q <= 1'b0;
            end
        end
    end

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {lane_q, result};
        end
    end

    // Outputs read zero while empty so they are defined out of reset.
    assign head     = mem_q[rd_ptr_q];
    assign out_data = out_valid ? head[31:0] : 32'd0;
    assign out_lane = out_valid ? head[33:32] : 2'd0;

endmodule
